// File: rtl/ccd_readout_sequencer.sv
// Frame sequencer for the line-sensor path: trigger edge detect, shift-gate pulse,
// programmable exposure, then N pixel clocks with a per-pixel capture strobe.
module ccd_readout_sequencer #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned N_PIXELS = 8,
    parameter int unsigned SH_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_in,
    input  logic        enable,
    input  logic [15:0] exp_time,
    output logic        sh_out,
    output logic        ccd_clk,
    output logic        pix_valid,
    output logic [11:0] pix_index,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StSh,
        StExpose,
        StRead,
        StDone
    } state_t;

    localparam logic [31:0] ShLast  = 32'(SH_WIDTH - 1);
    localparam logic [31:0] PhLast  = 32'(2 * CLK_DIV - 1);
    localparam logic [31:0] PhHigh  = 32'(CLK_DIV);
    localparam logic [11:0] PixLast = 12'(N_PIXELS - 1);

    state_t      state_q, state_d;
    logic [1:0]  trg_q, trg_d;
    logic [31:0] cnt_q, cnt_d;   // cycle counter for SH and EXPOSE
    logic [31:0] ph_q, ph_d;     // phase within the current pixel
    logic [11:0] pix_q, pix_d;
    logic [15:0] exp_q, exp_d;   // latched exposure, already clamped to >= 1
    logic [7:0]  ovr_q, ovr_d;
    logic        start;

    // Trigger edge: previous sample low, current sample high.
    assign start = (trg_q == 2'b01);

    // State and counter registers; reset also discards any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            trg_q   <= 2'b11;
            cnt_q   <= '0;
            ph_q    <= '0;
            pix_q   <= '0;
            exp_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            trg_q   <= trg_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pix_q   <= pix_d;
            exp_q   <= exp_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic for the frame FSM, synchronizer and overrun counter.
    always_comb begin
        state_d = state_q;
        trg_d   = {trg_q[0], trig_in};
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pix_d   = pix_q;
        exp_d   = exp_q;
        ovr_d   = ovr_q;

        // Any start outside IDLE is dropped and counted, saturating.
        if (start && (state_q != StIdle) && (ovr_q != 8'hff)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (start && enable) begin
                    state_d = StSh;
                    cnt_d   = '0;
                    exp_d   = (exp_time == 16'd0) ? 16'd1 : exp_time;
                end
            end
            StSh: begin
                if (cnt_q == ShLast) begin
                    state_d = StExpose;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StExpose: begin
                if (cnt_q == ({16'd0, exp_q} - 32'd1)) begin
                    state_d = StRead;
                    cnt_d   = '0;
                    ph_d    = '0;
                    pix_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRead: begin
                if (ph_q == PhLast) begin
                    ph_d = '0;
                    if (pix_q == PixLast) begin
                        state_d = StDone;
                        pix_d   = '0;
                    end else begin
                        pix_d = pix_q + 12'd1;
                    end
                end else begin
                    ph_d = ph_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                pix_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so no input reaches an output.
    always_comb begin
        sh_out      = (state_q == StSh);
        ccd_clk     = (state_q == StRead) && (ph_q >= PhHigh);
        pix_valid   = (state_q == StRead) && (ph_q == PhLast);
        pix_index   = pix_q;
        busy        = (state_q != StIdle);
        frame_done  = (state_q == StDone);
        overrun_cnt = ovr_q;
    end

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Bench for ccd_readout_sequencer: timeline model checked every cycle plus
// hand-computed edge numbers for each directed scenario.
module tb_ccd_readout_sequencer;

    localparam int CD  = 2;
    localparam int NP  = 8;
    localparam int SHW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig_in;
    logic        enable;
    logic [15:0] exp_time;
    logic        sh_out, ccd_clk, pix_valid, busy, frame_done;
    logic [11:0] pix_index;
    logic [7:0]  overrun_cnt;

    ccd_readout_sequencer #(
        .CLK_DIV (CD),
        .N_PIXELS(NP),
        .SH_WIDTH(SHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .enable     (enable),
        .exp_time   (exp_time),
        .sh_out     (sh_out),
        .ccd_clk    (ccd_clk),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun_cnt(overrun_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // A frame accepted at edge f0 occupies edges f0 .. f0+L-1.
    int         m_n      = 0;
    int         m_active = 0;
    int         m_f0     = 0;
    int         m_e      = 1;
    int         m_prev   = 1;
    int         m_pend   = 0;
    logic [7:0] m_ovr    = 8'd0;

    function automatic int busy_len(input int e);
        return SHW + e + NP * 2 * CD + 1;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_prev   = 1;
        m_pend   = 0;
        m_ovr    = 8'd0;
    endtask

    task automatic model_edge();
        int cur;
        m_n++;
        cur = int'(trig_in);
        if (m_pend != 0) begin
            if (m_active != 0 && (m_n - 1) <= (m_f0 + busy_len(m_e) - 1)) begin
                if (m_ovr != 8'd255) m_ovr = m_ovr + 8'd1;
            end else if (enable) begin
                m_active = 1;
                m_f0     = m_n;
                m_e      = (exp_time == 16'd0) ? 1 : int'(exp_time);
            end
        end
        m_pend = (cur == 1 && m_prev == 0) ? 1 : 0;
        m_prev = cur;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            logic [24:0] expv, actv;
            int r, rr, len, ph;
            logic e_sh, e_ccd, e_pv, e_busy, e_done;
            logic [11:0] e_pix;
            @(negedge clk);
            e_sh = 0; e_ccd = 0; e_pv = 0; e_busy = 0; e_done = 0; e_pix = '0;
            len = busy_len(m_e);
            r   = m_n - m_f0;
            if (!rst && m_active != 0 && r >= 0 && r <= len - 1) begin
                e_busy = 1;
                e_sh   = (r < SHW);
                e_done = (r == len - 1);
                rr     = r - (SHW + m_e);
                if (rr >= 0 && rr < NP * 2 * CD) begin
                    ph    = rr % (2 * CD);
                    e_pix = 12'(rr / (2 * CD));
                    e_ccd = (ph >= CD);
                    e_pv  = (ph == 2 * CD - 1);
                end
            end
            expv = {e_sh, e_ccd, e_pv, e_pix, e_busy, e_done, m_ovr};
            actv = {sh_out, ccd_clk, pix_valid, pix_index, busy, frame_done, overrun_cnt};
            n_checks++;
            if (actv !== expv) begin
                n_fail++;
                $display("FAIL cycle_model edge %0d: got sh/ccd/pv/pix/busy/done/ovr=%h, expected %h",
                         m_n, actv, expv);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    bit pat [0:2047];
    int sh_first, sh_last, ccd_first, pv_cnt, pv_first, pv_last, pv_badidx;
    int done_cnt, done_last, busy_first, busy_last, busy_cnt;

    task automatic clr_pat();
        for (int i = 0; i < 2048; i++) pat[i] = 1'b0;
    endtask

    // Edge k of the run samples pat[k]; edge 0 is where a leading pat[0]=1 rises.
    task automatic run(input int len, input int rst_at, input int chg_at);
        sh_first = -1; sh_last = -1; ccd_first = -1; pv_cnt = 0; pv_first = -1;
        pv_last = -1; pv_badidx = 0; done_cnt = 0; done_last = -1;
        busy_first = -1; busy_last = -1; busy_cnt = 0;
        for (int k = 0; k < len; k++) begin
            trig_in = pat[k];
            @(posedge clk);
            #2;
            if (sh_out) begin
                if (sh_first < 0) sh_first = k;
                sh_last = k;
            end
            if (ccd_clk && ccd_first < 0) ccd_first = k;
            if (pix_valid) begin
                if (int'(pix_index) != (pv_cnt % NP)) pv_badidx++;
                if (pv_first < 0) pv_first = k;
                pv_last = k;
                pv_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
                done_last = k;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
                busy_cnt++;
            end
            if (k == chg_at) begin
                enable   = 1'b0;
                exp_time = 16'd0;
            end
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_async_clear",
                    int'({sh_out, ccd_clk, pix_valid, pix_index, busy, frame_done, overrun_cnt}), 0);
            end
            if (rst_at >= 0 && k == rst_at + 2) rst = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        trig_in  = 1'b0;
        enable   = 1'b1;
        exp_time = 16'd5;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs",
            int'({sh_out, ccd_clk, pix_valid, pix_index, busy, frame_done, overrun_cnt}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Basic frame, exp_time = 5.
        clr_pat();
        for (int i = 0; i < 4; i++) pat[i] = 1'b1;
        run(50, -1, -1);
        chk("basic_sh_first", sh_first, 1);
        chk("basic_sh_last", sh_last, 3);
        chk("basic_ccd_first", ccd_first, 11);
        chk("basic_pv_first", pv_first, 12);
        chk("basic_pv_last", pv_last, 40);
        chk("basic_pv_cnt", pv_cnt, 8);
        chk("basic_pv_index", pv_badidx, 0);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_edge", done_last, 41);
        chk("basic_busy_first", busy_first, 1);
        chk("basic_busy_last", busy_last, 41);

        // Zero exposure behaves as one cycle.
        exp_time = 16'd0;
        run(45, -1, -1);
        chk("exp0_pv_first", pv_first, 8);
        chk("exp0_done_edge", done_last, 37);
        chk("exp0_busy_last", busy_last, 37);
        chk("exp0_pv_cnt", pv_cnt, 8);

        // Retriggers at edges 10 and 20 inside one frame.
        exp_time = 16'd5;
        for (int i = 10; i < 14; i++) pat[i] = 1'b1;
        for (int i = 20; i < 24; i++) pat[i] = 1'b1;
        run(50, -1, -1);
        chk("ovr_two", int'(overrun_cnt), 2);
        chk("ovr_done_cnt", done_cnt, 1);
        chk("ovr_done_edge", done_last, 41);

        // 300 rising edges over one long frame: counter saturates.
        exp_time = 16'd1000;
        clr_pat();
        for (int i = 0; i < 600; i += 2) pat[i] = 1'b1;
        run(1100, -1, -1);
        chk("ovr_saturate", int'(overrun_cnt), 255);
        chk("long_done_cnt", done_cnt, 1);
        chk("long_done_edge", done_last, 1036);

        // Trigger while disabled: ignored and not counted.
        exp_time = 16'd5;
        enable   = 1'b0;
        clr_pat();
        for (int i = 0; i < 4; i++) pat[i] = 1'b1;
        run(20, -1, -1);
        chk("disabled_no_busy", busy_first, -1);
        chk("disabled_ovr_kept", int'(overrun_cnt), 255);
        enable = 1'b1;

        // trig_in held high across reset release: no frame.
        trig_in = 1'b1;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) pat[i] = 1'b1;
        run(20, -1, -1);
        chk("trig_high_at_reset_no_busy", busy_first, -1);
        chk("reset_clears_ovr", int'(overrun_cnt), 0);
        clr_pat();
        run(5, -1, -1);

        // Reset mid-READ at edge 20, then a fresh frame with enable/exp_time
        // disturbed mid-frame.
        for (int i = 0; i < 4; i++) pat[i] = 1'b1;
        run(30, 20, -1);
        chk("rst_mid_no_done", done_cnt, 0);
        run(50, -1, 5);
        enable   = 1'b1;
        exp_time = 16'd5;
        chk("fresh_sh_first", sh_first, 1);
        chk("fresh_pv_first", pv_first, 12);
        chk("fresh_pv_cnt", pv_cnt, 8);
        chk("fresh_done_edge", done_last, 41);

        // Retrigger in the first IDLE cycle after frame_done.
        for (int i = 42; i < 46; i++) pat[i] = 1'b1;
        run(90, -1, -1);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_done_edge", done_last, 83);
        chk("b2b_sh_last", sh_last, 45);
        chk("b2b_busy_cnt", busy_cnt, 82);
        chk("b2b_pv_cnt", pv_cnt, 16);
        chk("b2b_pv_index", pv_badidx, 0);
        chk("b2b_ovr", int'(overrun_cnt), 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
